// File: rtl/da_pkg.sv
// rtl/da_pkg.sv - shared constants and loader state encodings for the DA FIR preload path
package da_pkg;

    localparam int DA_DATA_W = 16;
    localparam int DA_ADDR_W = 4;
    localparam int DA_DEPTH  = 16;

    // ROM enables are active-low
    localparam logic ON  = 1'b0;
    localparam logic OFF = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/da_rom_loader.sv
// rtl/da_rom_loader.sv - streams precomputed DA words into sequential ROM addresses
module da_rom_loader
    import da_pkg::*;
#(
    parameter int DATA_W = DA_DATA_W,
    parameter int ADDR_W = DA_ADDR_W,
    parameter int DEPTH  = DA_DEPTH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load_req,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_out,
    output logic              cload,
    output logic              rom_cen,
    output logic              rom_wen,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [DATA_W-1:0] rom_d,
    output logic              rom_ready,
    output logic              err_stray
);

    // one extra bit so the counter can never wrap back onto address 0
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ready_out_q, ready_out_d;
    logic              cload_q, cload_d;
    logic              rom_cen_q, rom_cen_d;
    logic              rom_wen_q, rom_wen_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] rom_d_q, rom_d_d;
    logic              rom_ready_q, rom_ready_d;
    logic              err_stray_q, err_stray_d;

    logic accept;
    logic start;

    // next-state, counter and registered ROM-port values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        rom_d_d    = rom_d_q;
        accept     = valid_in & ready_out_q;
        start      = load_req & (state_q != ST_LOAD);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_req) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            rom_addr_d = cnt_q[ADDR_W-1:0];
            rom_d_d    = data_in;
        end
        rom_cen_d   = accept ? ON : OFF;
        rom_wen_d   = accept ? ON : OFF;
        ready_out_d = (state_d == ST_LOAD);
        cload_d     = (state_d == ST_LOAD);
        // rises only once the final write has actually been presented to the ROM
        rom_ready_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        // a starting load clears the flag even if a stray word arrives with it
        err_stray_d = start ? 1'b0 : (err_stray_q | (valid_in & (state_q != ST_LOAD)));
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_out_q <= 1'b0;
            cload_q     <= 1'b0;
            rom_cen_q   <= OFF;
            rom_wen_q   <= OFF;
            rom_addr_q  <= '0;
            rom_d_q     <= '0;
            rom_ready_q <= 1'b0;
            err_stray_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_out_q <= ready_out_d;
            cload_q     <= cload_d;
            rom_cen_q   <= rom_cen_d;
            rom_wen_q   <= rom_wen_d;
            rom_addr_q  <= rom_addr_d;
            rom_d_q     <= rom_d_d;
            rom_ready_q <= rom_ready_d;
            err_stray_q <= err_stray_d;
        end
    end

    assign ready_out = ready_out_q;
    assign cload     = cload_q;
    assign rom_cen   = rom_cen_q;
    assign rom_wen   = rom_wen_q;
    assign rom_addr  = rom_addr_q;
    assign rom_d     = rom_d_q;
    assign rom_ready = rom_ready_q;
    assign err_stray = err_stray_q;

endmodule

// File: tb/tb_da_rom_loader.sv
// tb/tb_da_rom_loader.sv - directed self-checking bench for da_rom_loader
module tb_da_rom_loader;

    logic        clk;
    logic        resetn;
    logic        load_req;
    logic        valid_in;
    logic [15:0] data_in;
    logic        ready_out;
    logic        cload;
    logic        rom_cen;
    logic        rom_wen;
    logic [3:0]  rom_addr;
    logic [15:0] rom_d;
    logic        rom_ready;
    logic        err_stray;

    int tests;
    int fails;

    logic [15:0] mem [16];
    int          wr_cnt;

    da_rom_loader dut (
        .clk       (clk),
        .resetn    (resetn),
        .load_req  (load_req),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .cload     (cload),
        .rom_cen   (rom_cen),
        .rom_wen   (rom_wen),
        .rom_addr  (rom_addr),
        .rom_d     (rom_d),
        .rom_ready (rom_ready),
        .err_stray (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ROM: commits a write on the edge ending each enabled cycle
    initial wr_cnt = 0;
    always @(posedge clk) begin
        if (resetn && rom_cen == 1'b0 && rom_wen == 1'b0) begin
            mem[rom_addr] <= rom_d;
            wr_cnt        <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // full 16-word load; gap inserts two idle cycles after each word,
    // mid_req pulses load_req alongside that word index (-1 = none),
    // stray drives a word together with the starting load_req
    task automatic do_load(input logic [15:0] base, input bit gap, input int mid_req, input bit stray);
        int start_cnt;
        start_cnt = wr_cnt;
        load_req  = 1'b1;
        valid_in  = stray;
        data_in   = 16'hBEEF;
        tick();
        load_req = 1'b0;
        valid_in = 1'b0;
        check("start_cload", cload, 1);
        check("start_ready", ready_out, 1);
        check("start_no_write", rom_cen, 1);
        check("start_rom_ready_low", rom_ready, 0);
        check("start_err_clear", err_stray, 0);
        for (int k = 0; k < 16; k++) begin
            valid_in = 1'b1;
            data_in  = base + 16'(k);
            load_req = (k == mid_req);
            tick();
            load_req = 1'b0;
            valid_in = 1'b0;
            data_in  = 16'hDEAD;
            check($sformatf("w%0d_cen", k), rom_cen, 0);
            check($sformatf("w%0d_wen", k), rom_wen, 0);
            check($sformatf("w%0d_addr", k), rom_addr, k);
            check($sformatf("w%0d_data", k), rom_d, base + 16'(k));
            check($sformatf("w%0d_cload", k), cload, (k < 15));
            check($sformatf("w%0d_ready", k), ready_out, (k < 15));
            check($sformatf("w%0d_rom_ready", k), rom_ready, 0);
            if (gap && k < 15) begin
                for (int g = 0; g < 2; g++) begin
                    tick();
                    check($sformatf("gap%0d_cen", k), rom_cen, 1);
                    check($sformatf("gap%0d_rom_ready", k), rom_ready, 0);
                    check($sformatf("gap%0d_ready", k), ready_out, 1);
                end
            end
        end
        tick();
        check("end_no_write", rom_cen, 1);
        check("end_rom_ready", rom_ready, 1);
        check("end_cload", cload, 0);
        check("end_wr_count", wr_cnt - start_cnt, 16);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("mem%0d", k), mem[k], base + 16'(k));
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        resetn   = 1'b0;
        load_req = 1'b0;
        valid_in = 1'b0;
        data_in  = 16'h0000;
        tick();
        tick();
        check("rst_ready", ready_out, 0);
        check("rst_cload", cload, 0);
        check("rst_cen", rom_cen, 1);
        check("rst_wen", rom_wen, 1);
        check("rst_addr", rom_addr, 0);
        check("rst_d", rom_d, 0);
        check("rst_rom_ready", rom_ready, 0);
        check("rst_err", err_stray, 0);
        resetn = 1'b1;
        tick();

        // stray word in IDLE, then load_req together with a stray word
        valid_in = 1'b1;
        data_in  = 16'hBEEF;
        tick();
        valid_in = 1'b0;
        check("stray_no_write", rom_cen, 1);
        check("stray_err", err_stray, 1);
        check("stray_ready", ready_out, 0);
        tick();
        check("stray_err_sticky", err_stray, 1);

        // back-to-back load 0x0000..0x000F, started with a simultaneous stray word
        do_load(16'h0000, 1'b0, -1, 1'b1);

        // same load with gaps
        do_load(16'h0000, 1'b1, -1, 1'b0);

        // reset after 7 accepted words
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            valid_in = 1'b1;
            data_in  = 16'h5500 + 16'(k);
            tick();
        end
        valid_in = 1'b0;
        check("pre_rst_write", rom_addr, 6);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_cen", rom_cen, 1);
        check("midrst_wen", rom_wen, 1);
        check("midrst_cload", cload, 0);
        check("midrst_rom_ready", rom_ready, 0);
        check("midrst_ready", ready_out, 0);
        tick();
        check("midrst_idle", ready_out, 0);
        do_load(16'h0100, 1'b0, -1, 1'b0);

        // load_req pulsed alongside word 5 is ignored
        do_load(16'h0200, 1'b0, 5, 1'b0);

        // reload from DONE
        check("done_before_reload", rom_ready, 1);
        do_load(16'hA000, 1'b0, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
